mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single-port unified memory between the instruction-fetch unit (IF) and the load/store unit (LS) inside top.
Each requester holds a request until the arbiter returns a one-cycle done pulse.
The arbiter serialises accesses, drives the memory port and returns read data.
Both requesters asserting together are served in round-robin order, so neither starves.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
MEM_LAT, 1, memory read latency in cycles (legal range 1..4): data is valid MEM_LAT cycles after the cycle mem_en is high

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  IF request; held with payload until if_done
if_addr  input  ADDR_W  IF address (IF is read-only)
if_done  output  1  one-cycle completion pulse to IF
if_rdata  output  DATA_W  IF read data, valid when if_done=1, held afterwards
ls_req  input  1  LS request; held with payload until ls_done
ls_we  input  1  LS write enable (1 = write, 0 = read)
ls_addr  input  ADDR_W  LS address
ls_wdata  input  DATA_W  LS write data
ls_done  output  1  one-cycle completion pulse to LS
ls_rdata  output  DATA_W  LS read data, valid when ls_done=1 for a read, held afterwards
mem_en  output  1  memory access strobe, exactly one cycle per access
mem_we  output  1  memory write enable, qualified by mem_en
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data
busy  output  1  high in every state except IDLE
gnt_ls  output  1  owner of the current or most recent access (0 = IF, 1 = LS)

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. if_done, ls_done, mem_en, mem_we, busy are 0. All data/address outputs are 0. gnt_ls=1, so IF wins the first tie.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled only in this state.
  - Only one req high: grant it.
  - Both high: grant the requester opposite to gnt_ls.
  - On grant: latch the winner's addr, we (IF forces 0) and wdata; update gnt_ls; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (1 cycle): mem_en=1 with mem_we, mem_addr, mem_wdata from the latched copy.
  - Write: go to DONE.
  - Read: go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles, counted by an internal counter.
  - At the end of the last WAIT cycle, capture mem_rdata into the owner's rdata register.
  - Then go to DONE.
- DONE (1 cycle): owner's done=1; requests are ignored; go to IDLE.
- Timing from req seen in IDLE at cycle 0:
  - Read: done in cycle 2+MEM_LAT.
  - Write: done in cycle 2.
- Requester protocol:
  - A requester must drop or renew req on the edge where it samples done=1.
  - A req still high in the following IDLE cycle is a new request.
- Payload latched at grant; later changes to requester inputs do not affect the in-flight access.
- Outside ISSUE: mem_en=0 and mem_we=0; mem_addr/mem_wdata hold their last value.
- The non-owner's done stays 0. Its rdata register is unchanged.
- Writes leave ls_rdata unchanged.
- Back-to-back accesses, minimum spacing: next grant comes in the IDLE cycle right after DONE.
  - Throughput: one read per 3+MEM_LAT cycles, one write per 3 cycles.
- Round-robin pointer advances on every grant, including uncontested ones.
- Reset asserted mid-access: the access is abandoned with no done pulse. mem_en drops immediately and all registers return to their reset values. Requesters must reissue.

Test Plan:
- IF read, MEM_LAT=1, mem[0x10]=0xA5, if_req at cycle 0 with addr 0x10 -> mem_en=1, mem_addr=0x10 in cycle 1; if_done=1, if_rdata=0xA5 in cycle 3; busy low from cycle 4.
- LS write addr 0x20, data 0x5C -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x5C in cycle 1 only; ls_done in cycle 2; ls_rdata unchanged.
- Both req high after reset and held -> IF served first (gnt_ls=0), then LS, then IF again; each done exactly once per service; no two mem_en pulses closer than 3 cycles.
- LS holds req for 4 consecutive reads of 0x00..0x03 with MEM_LAT=1 -> ls_done spaced 4 cycles apart, ls_rdata matches memory each time, never two pulses for one request.
- reset pulled low in the WAIT cycle of an IF read -> mem_en, busy, if_done all 0 immediately; no if_done after release; a reissued req completes normally.
- MEM_LAT=3, IF read of 0x7F holding 0x3C -> if_done in cycle 5 with if_rdata=0x3C; mem_rdata garbage in cycles 2-3 is not captured.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port memory between IF and LS
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_ls
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic gnt_ls_q, gnt_ls_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic if_done_q, if_done_d, ls_done_q, ls_done_d, busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic pick_ls;
  // LS wins when it is alone or when IF was the most recent owner
  assign pick_ls = ls_req & (~if_req | ~gnt_ls_q);
  // Next state and next registered outputs; the memory port registers double as the latched payload
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_ls_d    = gnt_ls_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      S_IDLE: if (if_req | ls_req) begin
        state_d     = S_ISSUE;
        gnt_ls_d    = pick_ls;
        mem_addr_d  = pick_ls ? ls_addr : if_addr;
        mem_wdata_d = pick_ls ? ls_wdata : mem_wdata_q;
        mem_en_d    = 1'b1;
        mem_we_d    = pick_ls & ls_we;
      end
      S_ISSUE: begin
        state_d = mem_we_q ? S_DONE : S_WAIT;
        cnt_d   = 3'd0;
      end
      S_WAIT: if (cnt_q == LAST) begin
        state_d    = S_DONE;
        if_rdata_d = gnt_ls_q ? if_rdata_q : mem_rdata;
        ls_rdata_d = gnt_ls_q ? mem_rdata : ls_rdata_q;
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if_done_d = (state_d == S_DONE) & ~gnt_ls_q;
    ls_done_d = (state_d == S_DONE) & gnt_ls_q;
    busy_d    = state_d != S_IDLE;
  end
  // State and output registers; IF wins the first tie out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_ls_q    <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_ls_q    <= gnt_ls_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      busy_q      <= busy_d;
    end
  end
  assign if_done   = if_done_q;
  assign if_rdata  = if_rdata_q;
  assign ls_done   = ls_done_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign gnt_ls    = gnt_ls_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of mem_port_arbiter with MEM_LAT=1 and MEM_LAT=3
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic if_req, ls_req, ls_we, if_done, ls_done, mem_en, mem_we, busy, gnt_ls;
  logic [7:0] if_addr, ls_addr, ls_wdata, if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_req3, if_done3, ls_done3, mem_en3, mem_we3, busy3, gnt_ls3;
  logic [7:0] if_addr3, if_rdata3, ls_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic v1 = 1'b0;
  logic [7:0] dat1 = '0;
  logic [2:0] v3 = '0;
  logic [7:0] d3 [3];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_ls(gnt_ls)
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_done(if_done3), .if_rdata(if_rdata3),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(8'h00), .ls_wdata(8'h00),
    .ls_done(ls_done3), .ls_rdata(ls_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3), .gnt_ls(gnt_ls3)
  );

  // Read-only memory image; writes are checked on the port pins instead
  function automatic logic [7:0] mem_img(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a == 8'h7F) ? 8'h3C : (a ^ 8'h5A);
  endfunction

  // Memory with latency; 8'hC3 is driven whenever read data is not valid
  always @(posedge clk) begin
    v1   <= mem_en & ~mem_we;
    dat1 <= mem_img(mem_addr);
    v3   <= {v3[1:0], mem_en3 & ~mem_we3};
    d3[0] <= mem_img(mem_addr3);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign mem_rdata  = v1 ? dat1 : 8'hC3;
  assign mem_rdata3 = v3[2] ? d3[2] : 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    if_req3 = 0; if_addr3 = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_done", if_done, 0);
    chk("rst_ls_done", ls_done, 0);
    chk("rst_gnt_ls", gnt_ls, 1);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    reset = 1'b1;
    tick();
    // IF read of 0x10
    if_req = 1; if_addr = 8'h10;
    tick();
    chk("ifr_c1_en", mem_en, 1);
    chk("ifr_c1_addr", mem_addr, 8'h10);
    chk("ifr_c1_we", mem_we, 0);
    chk("ifr_c1_gnt", gnt_ls, 0);
    chk("ifr_c1_busy", busy, 1);
    tick();
    chk("ifr_c2_en", mem_en, 0);
    chk("ifr_c2_done", if_done, 0);
    tick();
    chk("ifr_c3_done", if_done, 1);
    chk("ifr_c3_rdata", if_rdata, 8'hA5);
    chk("ifr_c3_lsdone", ls_done, 0);
    if_req = 0;
    tick();
    chk("ifr_c4_busy", busy, 0);
    chk("ifr_c4_done", if_done, 0);
    chk("ifr_c4_rdata", if_rdata, 8'hA5);
    // LS write 0x5C to 0x20, payload changed after grant
    ls_req = 1; ls_we = 1; ls_addr = 8'h20; ls_wdata = 8'h5C;
    tick();
    chk("lsw_c1_en", mem_en, 1);
    chk("lsw_c1_we", mem_we, 1);
    chk("lsw_c1_addr", mem_addr, 8'h20);
    chk("lsw_c1_wdata", mem_wdata, 8'h5C);
    chk("lsw_c1_gnt", gnt_ls, 1);
    ls_addr = 8'h99; ls_wdata = 8'hFF;
    tick();
    chk("lsw_c2_en", mem_en, 0);
    chk("lsw_c2_we", mem_we, 0);
    chk("lsw_c2_addr", mem_addr, 8'h20);
    chk("lsw_c2_done", ls_done, 1);
    chk("lsw_c2_rdata", ls_rdata, 0);
    ls_req = 0; ls_we = 0;
    tick();
    chk("lsw_c3_done", ls_done, 0);
    chk("lsw_c3_busy", busy, 0);
    // Contention after reset: IF, LS, IF
    reset = 0; tick(); reset = 1; tick();
    chk("rr_rst_gnt", gnt_ls, 1);
    if_req = 1; if_addr = 8'h01; ls_req = 1; ls_addr = 8'h02;
    tick();
    chk("rr_c1_en", mem_en, 1);
    chk("rr_c1_addr", mem_addr, 8'h01);
    chk("rr_c1_gnt", gnt_ls, 0);
    tick();
    chk("rr_c2_en", mem_en, 0);
    tick();
    chk("rr_c3_ifdone", if_done, 1);
    chk("rr_c3_lsdone", ls_done, 0);
    chk("rr_c3_rdata", if_rdata, 8'h5B);
    if_addr = 8'h03;
    tick();
    chk("rr_c4_en", mem_en, 0);
    chk("rr_c4_ifdone", if_done, 0);
    chk("rr_c4_busy", busy, 0);
    tick();
    chk("rr_c5_en", mem_en, 1);
    chk("rr_c5_addr", mem_addr, 8'h02);
    chk("rr_c5_gnt", gnt_ls, 1);
    tick();
    tick();
    chk("rr_c7_lsdone", ls_done, 1);
    chk("rr_c7_ifdone", if_done, 0);
    chk("rr_c7_rdata", ls_rdata, 8'h58);
    chk("rr_c7_ifrdata", if_rdata, 8'h5B);
    ls_req = 0;
    tick();
    chk("rr_c8_lsdone", ls_done, 0);
    chk("rr_c8_en", mem_en, 0);
    tick();
    chk("rr_c9_en", mem_en, 1);
    chk("rr_c9_addr", mem_addr, 8'h03);
    chk("rr_c9_gnt", gnt_ls, 0);
    tick();
    tick();
    chk("rr_c11_ifdone", if_done, 1);
    chk("rr_c11_rdata", if_rdata, 8'h59);
    if_req = 0;
    tick();
    chk("rr_c12_ifdone", if_done, 0);
    chk("rr_c12_busy", busy, 0);
    // LS back-to-back reads 0x00..0x03
    ls_req = 1; ls_we = 0; ls_addr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_en", mem_en, 1);
      chk("b2b_addr", mem_addr, i);
      tick();
      tick();
      chk("b2b_done", ls_done, 1);
      chk("b2b_rdata", ls_rdata, mem_img(8'(i)));
      if (i < 3) ls_addr = 8'(i + 1);
      else ls_req = 0;
      tick();
      chk("b2b_gap", ls_done, 0);
    end
    // Reset during WAIT of an IF read
    if_req = 1; if_addr = 8'h10;
    tick();
    tick();
    chk("ar_wait_busy", busy, 1);
    reset = 0; if_req = 0;
    #1;
    chk("ar_en", mem_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", if_done, 0);
    chk("ar_gnt", gnt_ls, 1);
    chk("ar_rdata", if_rdata, 0);
    tick();
    tick();
    reset = 1;
    tick();
    chk("ar_post1_done", if_done, 0);
    tick();
    chk("ar_post2_done", if_done, 0);
    chk("ar_post2_busy", busy, 0);
    if_req = 1; if_addr = 8'h10;
    tick();
    chk("ar_re_en", mem_en, 1);
    tick();
    tick();
    chk("ar_re_done", if_done, 1);
    chk("ar_re_rdata", if_rdata, 8'hA5);
    if_req = 0;
    tick();
    // MEM_LAT=3 IF read of 0x7F
    if_req3 = 1; if_addr3 = 8'h7F;
    tick();
    chk("l3_c1_en", mem_en3, 1);
    chk("l3_c1_addr", mem_addr3, 8'h7F);
    tick();
    chk("l3_c2_done", if_done3, 0);
    tick();
    chk("l3_c3_done", if_done3, 0);
    chk("l3_c3_busy", busy3, 1);
    tick();
    chk("l3_c4_done", if_done3, 0);
    tick();
    chk("l3_c5_done", if_done3, 1);
    chk("l3_c5_rdata", if_rdata3, 8'h3C);
    if_req3 = 0;
    tick();
    chk("l3_c6_done", if_done3, 0);
    chk("l3_c6_busy", busy3, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
